// File: rtl/mpu_pkg.sv
// mpu_pkg
//   Shared definitions for the MPU datapath blocks: ALU op codes, the
//   operand-fetch state encoding and the operand word width.
//   No ports (package).
package mpu_pkg;

    localparam int unsigned MPU_WORD_W = 64;

    // ALU op codes carried on the decoded-instruction bus
    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_MASK = 4'd1;
    localparam logic [3:0] OP_CMP  = 4'd2;
    localparam logic [3:0] OP_LT   = 4'd3;

    // Operand-fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_VALID = 2'd3
    } fetch_state_t;

    // Register reads performed when no op-specific shortcut applies
    localparam logic [1:0] FETCH_READS_FULL = 2'd3;

endpackage

// File: rtl/mpu_opfetch.sv
// mpu_opfetch
//   Operand fetch stage: accepts a decoded instruction, reads up to three
//   64-bit operands from a synchronous-read register file (one read per
//   cycle) and presents the instruction plus operands to the ALU with a
//   valid/ready handshake.
//
// Ports
//   sys_clk, sys_rst          clock, asynchronous active-high reset
//   i_valid / i_ready         decoded-instruction handshake (ready only in IDLE)
//   i_op, i_size, i_s0..i_s2  ALU op, operand size, operand selectors
//   i_r0..i_r2                operand register indices
//   rf_re, rf_addr, rf_data   register-file read port (data one cycle after rf_re)
//   a_op, a_size, a_s0..a_s2  registered instruction fields to the ALU
//   a_o0..a_o2                registered operands to the ALU
//   a_valid / a_ready         ALU-side handshake
//   flush                     synchronous abort back to IDLE
//
// Configuration
//   MPU_OPFETCH_SKIP_EN  when defined, op NONE reads no operands (straight to
//                        VALID) and op LT reads only two (a_o2 stays 0).
//                        Otherwise every op reads three operands.
module mpu_opfetch
    import mpu_pkg::*;
#(
    parameter int RF_AW = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,

    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [3:0]            i_op,
    input  logic [1:0]            i_size,
    input  logic [2:0]            i_s0,
    input  logic [2:0]            i_s1,
    input  logic [2:0]            i_s2,
    input  logic [RF_AW-1:0]      i_r0,
    input  logic [RF_AW-1:0]      i_r1,
    input  logic [RF_AW-1:0]      i_r2,

    output logic                  rf_re,
    output logic [RF_AW-1:0]      rf_addr,
    input  logic [MPU_WORD_W-1:0] rf_data,

    output logic [3:0]            a_op,
    output logic [1:0]            a_size,
    output logic [2:0]            a_s0,
    output logic [2:0]            a_s1,
    output logic [2:0]            a_s2,
    output logic [MPU_WORD_W-1:0] a_o0,
    output logic [MPU_WORD_W-1:0] a_o1,
    output logic [MPU_WORD_W-1:0] a_o2,
    output logic                  a_valid,
    input  logic                  a_ready,

    input  logic                  flush
);

    fetch_state_t     state;
    logic [RF_AW-1:0] r1_q;
    logic [RF_AW-1:0] r2_q;
    logic [1:0]       rd_k;       // index of the read currently on rf_re
    logic [1:0]       rd_n;       // number of reads for the latched instruction
    logic [1:0]       last_k;
    logic [RF_AW-1:0] next_addr;
    logic [1:0]       accept_reads;

    // One-deep capture pipeline: marks which operand rf_data belongs to
    logic             cap_valid;
    logic [1:0]       cap_idx;

    assign i_ready = (state == ST_IDLE);

    always_comb begin
        accept_reads = FETCH_READS_FULL;
`ifdef MPU_OPFETCH_SKIP_EN
        if (i_op == OP_NONE) begin
            accept_reads = 2'd0;
        end else if (i_op == OP_LT) begin
            accept_reads = 2'd2;
        end
`endif
    end

    // r0 is issued straight from the input on accept, so only r1/r2 are held
    assign next_addr = (rd_k == 2'd0) ? r1_q : r2_q;
    assign last_k    = rd_n - 2'd1;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            r1_q      <= '0;
            r2_q      <= '0;
            rd_k      <= '0;
            rd_n      <= '0;
            cap_valid <= 1'b0;
            cap_idx   <= '0;
            rf_re     <= 1'b0;
            rf_addr   <= '0;
            a_valid   <= 1'b0;
            a_op      <= '0;
            a_size    <= '0;
            a_s0      <= '0;
            a_s1      <= '0;
            a_s2      <= '0;
            a_o0      <= '0;
            a_o1      <= '0;
            a_o2      <= '0;
        end else begin
            // Capture stage runs alongside the sequencer; a flush kills both
            // the in-flight capture and the one being launched.
            cap_valid <= rf_re & ~flush;
            cap_idx   <= rd_k;
            if (cap_valid && !flush) begin
                case (cap_idx)
                    2'd0:    a_o0 <= rf_data;
                    2'd1:    a_o1 <= rf_data;
                    default: a_o2 <= rf_data;
                endcase
            end

            if (flush) begin
                state   <= ST_IDLE;
                rf_re   <= 1'b0;
                rf_addr <= '0;
                a_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_valid) begin
                            a_op   <= i_op;
                            a_size <= i_size;
                            a_s0   <= i_s0;
                            a_s1   <= i_s1;
                            a_s2   <= i_s2;
                            a_o0   <= '0;
                            a_o1   <= '0;
                            a_o2   <= '0;
                            r1_q   <= i_r1;
                            r2_q   <= i_r2;
                            rd_n   <= accept_reads;
                            rd_k   <= '0;
                            if (accept_reads == 2'd0) begin
                                state   <= ST_VALID;
                                a_valid <= 1'b1;
                            end else begin
                                state   <= ST_ISSUE;
                                rf_re   <= 1'b1;
                                rf_addr <= i_r0;
                            end
                        end
                    end
                    ST_ISSUE: begin
                        if (rd_k == last_k) begin
                            state   <= ST_DRAIN;
                            rf_re   <= 1'b0;
                            rf_addr <= '0;
                        end else begin
                            rd_k    <= rd_k + 2'd1;
                            rf_addr <= next_addr;
                        end
                    end
                    ST_DRAIN: begin
                        // final capture lands this cycle
                        state   <= ST_VALID;
                        a_valid <= 1'b1;
                    end
                    ST_VALID: begin
                        if (a_ready) begin
                            state   <= ST_IDLE;
                            a_valid <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
